// File: rtl/pe_array_sequencer.sv
// Command sequencer for pe_array: one job = LOAD, N x (MAC, SHIFT A, SHIFT B), READ_OUT.
// Optional handshake watchdog with sticky error state: define PE_SEQ_TIMEOUT_EN.
module pe_array_sequencer #(
  parameter int STEP_W         = 8,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int TIMEOUT_W      = 10
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  input  logic [STEP_W-1:0] num_steps,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [STEP_W-1:0] step_count,
  input  logic              ready,
  output logic              array_ack,
  output logic [2:0]        command_to_execute,
  output logic              image_to_shift
);

  localparam logic [2:0] CMD_NOP   = 3'b000;
  localparam logic [2:0] CMD_MAC   = 3'b001;
  localparam logic [2:0] CMD_SHIFT = 3'b010;
  localparam logic [2:0] CMD_READ  = 3'b011;
  localparam logic [2:0] CMD_LOAD  = 3'b101;

  if (TIMEOUT_CYCLES >= (1 << TIMEOUT_W)) begin : g_timeout_w_chk
    $error("pe_array_sequencer: TIMEOUT_W too narrow for TIMEOUT_CYCLES");
  end

`ifdef PE_SEQ_TIMEOUT_EN
  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_ISSUE, S_WAIT_DONE, S_DONE, S_ERR
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_ISSUE, S_WAIT_DONE, S_DONE
  } state_t;
`endif

  state_t            state_q, state_d;
  logic [2:0]        cmd_q, cmd_d;
  logic              img_q, img_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [STEP_W-1:0] nsteps_q, nsteps_d;

  logic [2:0]        nxt_cmd;
  logic              nxt_img;
  logic [STEP_W-1:0] nxt_step;
  logic              last_cmd;

`ifdef PE_SEQ_TIMEOUT_EN
  logic                 error_q, error_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
`endif

  // Successor of the command currently held in cmd_q/img_q.
  always_comb begin
    nxt_cmd  = CMD_READ;
    nxt_img  = 1'b0;
    nxt_step = step_q;
    last_cmd = 1'b0;
    case (cmd_q)
      CMD_LOAD: begin
        if (nsteps_q != '0) begin
          nxt_cmd  = CMD_MAC;
          nxt_step = step_q + STEP_W'(1);
        end
      end
      CMD_MAC: nxt_cmd = CMD_SHIFT;
      CMD_SHIFT: begin
        if (!img_q) begin
          nxt_cmd = CMD_SHIFT;
          nxt_img = 1'b1;
        end else if (step_q != nsteps_q) begin
          nxt_cmd  = CMD_MAC;
          nxt_step = step_q + STEP_W'(1);
        end
      end
      default: last_cmd = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    img_d    = img_q;
    ack_d    = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    step_d   = step_q;
    nsteps_d = nsteps_q;
`ifdef PE_SEQ_TIMEOUT_EN
    error_d  = error_q;
    wd_d     = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_ARM;
          nsteps_d = num_steps;
          step_d   = '0;
          cmd_d    = CMD_LOAD;
          img_d    = 1'b0;
          busy_d   = 1'b1;
        end
      end
      S_ARM: begin
        if (ready) begin
          state_d = S_ISSUE;
          ack_d   = 1'b1;
        end
      end
      S_ISSUE: begin
        ack_d = 1'b1;
        if (!ready) begin
          state_d = S_WAIT_DONE;
          ack_d   = 1'b0;
        end
      end
      S_WAIT_DONE: begin
        if (ready) begin
          if (last_cmd) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            cmd_d   = CMD_NOP;
            img_d   = 1'b0;
          end else begin
            state_d = S_ISSUE;
            ack_d   = 1'b1;
            cmd_d   = nxt_cmd;
            img_d   = nxt_img;
            step_d  = nxt_step;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
`ifdef PE_SEQ_TIMEOUT_EN
      S_ERR: begin
        if (start) begin
          state_d  = S_ARM;
          nsteps_d = num_steps;
          step_d   = '0;
          cmd_d    = CMD_LOAD;
          img_d    = 1'b0;
          busy_d   = 1'b1;
          error_d  = 1'b0;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
`ifdef PE_SEQ_TIMEOUT_EN
    // Counter restarts on every phase entry; only a stalled phase can expire.
    if ((state_q == S_ARM || state_q == S_ISSUE || state_q == S_WAIT_DONE) &&
        state_d == state_q) begin
      if (wd_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
        state_d = S_ERR;
        ack_d   = 1'b0;
        cmd_d   = CMD_NOP;
        img_d   = 1'b0;
        busy_d  = 1'b0;
        error_d = 1'b1;
      end else begin
        wd_d = wd_q + TIMEOUT_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      cmd_q    <= CMD_NOP;
      img_q    <= 1'b0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      step_q   <= '0;
      nsteps_q <= '0;
`ifdef PE_SEQ_TIMEOUT_EN
      error_q  <= 1'b0;
      wd_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      img_q    <= img_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      step_q   <= step_d;
      nsteps_q <= nsteps_d;
`ifdef PE_SEQ_TIMEOUT_EN
      error_q  <= error_d;
      wd_q     <= wd_d;
`endif
    end
  end

  assign array_ack          = ack_q;
  assign command_to_execute = cmd_q;
  assign image_to_shift     = img_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign step_count         = step_q;
`ifdef PE_SEQ_TIMEOUT_EN
  assign error              = error_q;
`else
  assign error              = 1'b0;
`endif

endmodule

// File: tb/tb_pe_array_sequencer.sv
// Directed bench for pe_array_sequencer with a behavioural pe_array ready/ack model.
module tb_pe_array_sequencer;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       start;
  logic [7:0] num_steps;
  logic       busy, done, error;
  logic [7:0] step_count;
  logic       ready;
  logic       array_ack;
  logic [2:0] command_to_execute;
  logic       image_to_shift;

  int nvec = 0;
  int nerr = 0;

  always #5 CLK = ~CLK;

  pe_array_sequencer #(.STEP_W(8), .TIMEOUT_CYCLES(16), .TIMEOUT_W(10)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .num_steps(num_steps),
    .busy(busy), .done(done), .error(error), .step_count(step_count),
    .ready(ready), .array_ack(array_ack),
    .command_to_execute(command_to_execute), .image_to_shift(image_to_shift)
  );

  // pe_array model: ready drops 2 cycles after ack, rises 3 cycles later
  logic rst_test = 1'b0, rnd_rdy = 1'b0, stuck = 1'b0;
  logic m_rdy = 1'b1, m_busy = 1'b0;
  int   m_cnt = 0;
  assign ready = rst_test ? rnd_rdy : m_rdy;

  always @(negedge CLK) begin
    if (!RST_N) begin
      m_rdy = 1'b1; m_busy = 1'b0; m_cnt = 0;
    end else if (stuck) begin
      m_rdy = 1'b1;
    end else if (m_busy) begin
      m_cnt++;
      if (m_cnt == 2) m_rdy = 1'b0;
      if (m_cnt == 5) begin m_rdy = 1'b1; m_busy = 1'b0; end
    end else if (array_ack) begin
      m_busy = 1'b1; m_cnt = 0;
    end
  end

  // Monitor: log each issued command, count done pulses and protocol violations
  logic        rdy_s = 1'b1, ack_prev = 1'b0;
  logic [11:0] log_q[$];
  logic [11:0] exp_q[$];
  int          ndone = 0, nviol = 0, nerr_seen = 0, ndone_idle = 0;

  always @(posedge CLK) rdy_s = ready;

  always @(negedge CLK) begin
    if (array_ack && !ack_prev) log_q.push_back({command_to_execute, image_to_shift, step_count});
    ack_prev = array_ack;
    if (done) ndone++;
    if (done && !busy) ndone_idle++;
    if (array_ack && !rdy_s && RST_N) nviol++;
    if (error) nerr_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK); #1;
  endtask

  function automatic logic [11:0] e(input logic [2:0] c, input logic i, input logic [7:0] s);
    return {c, i, s};
  endfunction

  function automatic logic [31:0] outs();
    return {17'd0, array_ack, command_to_execute, image_to_shift, busy, done, error, step_count};
  endfunction

  // start accepted at edge t: ARM (LOAD loaded) at t, ack high at t+1
  task automatic begin_job(input logic [7:0] n);
    log_q.delete();
    ndone = 0;
    start = 1'b1; num_steps = n;
    tick();
    start = 1'b0; num_steps = 8'hA5;
    chk("arm_busy", busy, 1);
    chk("arm_ack", array_ack, 0);
    chk("arm_cmd", command_to_execute, 3'b101);
    tick();
    chk("issue_ack", array_ack, 1);
  endtask

  task automatic wait_done(input int max);
    for (int i = 0; i < max; i++) begin
      if (done) break;
      tick();
    end
    chk("done_seen", done, 1);
    chk("done_busy", busy, 1);
    tick();
    chk("post_done_busy", busy, 0);
    chk("post_done_pulse", done, 0);
  endtask

  task automatic cmp_log(input string tag);
    chk({tag, "_len"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk($sformatf("%s_%0d", tag, i), log_q[i], exp_q[i]);
  endtask

  task automatic wait_wait_done(input int max);
    int i;
    for (i = 0; i < max; i++) begin
      if (busy && !array_ack && !ready && log_q.size() >= 2) break;
      tick();
    end
    chk("reach_wait_done", (i < max), 1);
  endtask

  initial begin
    RST_N = 1'b0; start = 1'b0; num_steps = '0;

    // Reset with random inputs
    rst_test = 1'b1;
    for (int i = 0; i < 6; i++) begin
      start = 1'($urandom); num_steps = 8'($urandom); rnd_rdy = 1'($urandom);
      tick();
      chk("reset_outs", outs(), 0);
    end
    start = 1'b0; rst_test = 1'b0;
    tick();
    RST_N = 1'b1;
    tick(); tick();
    chk("idle_after_reset", outs(), 0);

    // N = 0
    begin_job(8'd0);
    wait_done(200);
    exp_q = '{e(3'b101, 0, 0), e(3'b011, 0, 0)};
    cmp_log("n0_seq");
    chk("n0_ndone", ndone, 1);
    chk("n0_step", step_count, 0);
    chk("n0_idle_outs", outs(), 0);

    // N = 2
    begin_job(8'd2);
    wait_done(400);
    exp_q = '{e(3'b101, 0, 0), e(3'b001, 0, 1), e(3'b010, 0, 1), e(3'b010, 1, 1),
              e(3'b001, 0, 2), e(3'b010, 0, 2), e(3'b010, 1, 2), e(3'b011, 0, 2)};
    cmp_log("n2_seq");
    chk("n2_ndone", ndone, 1);
    chk("n2_step_hold", step_count, 2);

    // N = 1 with stray start pulses in ISSUE and in WAIT_DONE
    begin_job(8'd1);
    start = 1'b1; num_steps = 8'd5;
    tick();
    start = 1'b0;
    wait_wait_done(100);
    start = 1'b1; num_steps = 8'd5;
    tick();
    start = 1'b0;
    wait_done(400);
    exp_q = '{e(3'b101, 0, 0), e(3'b001, 0, 1), e(3'b010, 0, 1), e(3'b010, 1, 1),
              e(3'b011, 0, 1)};
    cmp_log("stray_seq");
    chk("stray_ndone", ndone, 1);
    chk("stray_step", step_count, 1);
    tick(); tick();
    chk("stray_no_restart", busy, 0);

    // Async reset in WAIT_DONE, then restart from LOAD
    begin_job(8'd3);
    wait_wait_done(100);
    RST_N = 1'b0;
    #1;
    chk("midjob_reset_outs", outs(), 0);
    tick(); tick();
    RST_N = 1'b1;
    tick();
    chk("post_reset_idle", outs(), 0);
    begin_job(8'd1);
    wait_done(400);
    exp_q = '{e(3'b101, 0, 0), e(3'b001, 0, 1), e(3'b010, 0, 1), e(3'b010, 1, 1),
              e(3'b011, 0, 1)};
    cmp_log("restart_seq");
    chk("restart_ndone", ndone, 1);

    chk("ack_vs_ready", nviol, 0);
    chk("done_without_busy", ndone_idle, 0);

`ifdef PE_SEQ_TIMEOUT_EN
    begin : wd_test
      int nack;
      stuck = 1'b1;
      begin_job(8'd0);
      nack = 0;
      for (int i = 0; i < 100; i++) begin
        if (error) break;
        if (array_ack) nack++;
        tick();
      end
      chk("wd_issue_cycles", nack, 16);
      chk("wd_error", error, 1);
      chk("wd_ack", array_ack, 0);
      chk("wd_busy", busy, 0);
      chk("wd_cmd", command_to_execute, 0);
      tick(); tick();
      chk("wd_sticky", error, 1);
      stuck = 1'b0;
      begin_job(8'd0);
      chk("wd_cleared", error, 0);
      wait_done(200);
      exp_q = '{e(3'b101, 0, 0), e(3'b011, 0, 0)};
      cmp_log("wd_reissue");
    end
`else
    chk("error_tied_low", nerr_seen, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
